// File: rtl/ext_wait_ctrl.sv
// ext_wait_ctrl: stretches E by a per-select number of CLKX4 wait states, with a 4-byte wait-state register window.
// Build option EXT_WAIT_XWAIT_EN: nXWAIT handshake with timeout for nCSEXT/nCSEXTIO accesses.
module ext_wait_ctrl #(
  parameter logic [15:0] REG_BASE   = 16'hFE30,
  parameter logic [3:0]  RST_WAIT   = 4'hF,
  parameter logic [7:0]  TMO_CYCLES = 8'd255
) (
  input  logic        CLKX4,
  input  logic        nRESET,
  input  logic        QX,
  input  logic        EX,
  input  logic [15:0] ADDR,
  input  logic        RnW,
  inout  wire  [7:0]  DATA,
  input  logic        nCSROM0,
  input  logic        nCSROM1,
  input  logic        nCSRAM,
  input  logic        nCSEXT,
  input  logic        nCSEXTIO,
  input  logic        nCSUART,
  input  logic        nXWAIT,
  output logic        MRDY
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, STRETCH, XWAIT, FINAL} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [DW-1:0] wait0, wait1;
  logic [CW-1:0] wait2;
  logic          tmo;
  logic [DW-1:0] tmo_cnt;
  logic          ext_acc;
  logic [CW-1:0] sel_wait;
  logic          sel_ext;
  logic          xw_low;
  logic          win_hit, wr_commit, drive;
  logic [DW-1:0] rdata;

  wire ph_11 = QX & EX;
  wire ph_01 = ~QX & EX;

`ifdef EXT_WAIT_XWAIT_EN
  logic [1:0] xw_sync;

  // Two-flop synchronizer for the asynchronous wait request
  always_ff @(posedge CLKX4 or negedge nRESET) begin
    if (!nRESET) xw_sync <= 2'b11;
    else         xw_sync <= {xw_sync[0], nXWAIT};
  end

  assign xw_low = ~xw_sync[1];
`else
  wire unused_nxwait = nXWAIT;
  assign xw_low = 1'b0;
`endif

  // Wait count of the highest-priority active select
  always_comb begin
    sel_wait = '0;
    sel_ext  = 1'b0;
    if (!nCSUART)                  sel_wait = wait2;
    else if (!nCSEXTIO)          begin sel_wait = wait1[7:4]; sel_ext = 1'b1; end
    else if (!nCSEXT)            begin sel_wait = wait1[3:0]; sel_ext = 1'b1; end
    else if (!nCSRAM)              sel_wait = wait0[7:4];
    else if (!nCSROM0 || !nCSROM1) sel_wait = wait0[3:0];
  end

  assign win_hit   = (ADDR[15:2] == REG_BASE[15:2]) && !nCSEXTIO;
  assign wr_commit = win_hit && ph_01 && MRDY && !RnW;
  assign drive     = EX && RnW && win_hit;

  always_comb begin
    case (ADDR[1:0])
      2'd0:    rdata = wait0;
      2'd1:    rdata = wait1;
      2'd2:    rdata = {4'b0, wait2};
      default: rdata = {6'b0, 1'b0, tmo};
    endcase
  end

  assign DATA = drive ? rdata : {DW{1'bz}};

  // Register window and E-stretch state machine
  always_ff @(posedge CLKX4 or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      MRDY    <= 1'b1;
      count   <= '0;
      ext_acc <= 1'b0;
      tmo     <= 1'b0;
      tmo_cnt <= '0;
      wait0   <= {RST_WAIT, RST_WAIT};
      wait1   <= {RST_WAIT, RST_WAIT};
      wait2   <= RST_WAIT;
    end else begin
      if (wr_commit) begin
        case (ADDR[1:0])
          2'd0:    wait0 <= DATA;
          2'd1:    wait1 <= DATA;
          2'd2:    wait2 <= DATA[3:0];
          default: tmo   <= 1'b0;
        endcase
      end

      case (state)
        IDLE: begin
          if (ph_11) begin
            count   <= sel_wait;
            ext_acc <= sel_ext;
            if (sel_ext && xw_low) begin
              state   <= XWAIT;
              MRDY    <= 1'b0;
              tmo_cnt <= '0;
            end else if (sel_wait != '0) begin
              state <= STRETCH;
              MRDY  <= 1'b0;
            end else begin
              state <= FINAL;
              MRDY  <= 1'b1;
            end
          end
        end
        STRETCH: begin
          if (!EX) begin
            state <= IDLE;
            MRDY  <= 1'b1;
            count <= '0;
          end else if (!QX) begin
            count <= count - CW'(1);
            MRDY  <= (count == CW'(1));
            if (count == CW'(1)) begin
              if (ext_acc && xw_low) begin
                state   <= XWAIT;
                MRDY    <= 1'b0;
                tmo_cnt <= '0;
              end else begin
                state <= FINAL;
              end
            end
          end
        end
        XWAIT: begin
          if (!xw_low) begin
            state <= FINAL;
            MRDY  <= 1'b1;
          end else if (tmo_cnt == TMO_CYCLES - DW'(1)) begin
            state <= FINAL;
            MRDY  <= 1'b1;
            tmo   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + DW'(1);
          end
        end
        FINAL: begin
          if (!EX) begin
            state <= IDLE;
            MRDY  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          MRDY  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_wait_ctrl.sv
// Bench for ext_wait_ctrl: bus cycles with randomized selects/addresses/data against a register-level model.
// Define EXT_WAIT_XWAIT_EN for both files to exercise the nXWAIT handshake.
`timescale 1ns/1ps
module tb_ext_wait_ctrl;

  localparam logic [15:0] BASE = 16'hFE30;
  localparam int          TMO  = 255;

  logic        CLKX4 = 1'b0;
  logic        nRESET;
  logic        QX, EX;
  logic [15:0] ADDR;
  logic        RnW;
  wire  [7:0]  DATA;
  logic [7:0]  tb_dout;
  logic        tb_drv;
  logic [5:0]  sel_n;  // {UART, EXTIO, EXT, RAM, ROM1, ROM0}, active-low
  wire         nCSROM0, nCSROM1, nCSRAM, nCSEXT, nCSEXTIO, nCSUART;
  logic        nXWAIT;
  logic        MRDY;

  assign {nCSUART, nCSEXTIO, nCSEXT, nCSRAM, nCSROM1, nCSROM0} = sel_n;
  assign DATA = tb_drv ? tb_dout : 8'bzzzzzzzz;

  always #5 CLKX4 = ~CLKX4;

  ext_wait_ctrl #(.REG_BASE(BASE), .RST_WAIT(4'hF), .TMO_CYCLES(8'd255)) dut (
    .CLKX4(CLKX4), .nRESET(nRESET), .QX(QX), .EX(EX), .ADDR(ADDR), .RnW(RnW), .DATA(DATA),
    .nCSROM0(nCSROM0), .nCSROM1(nCSROM1), .nCSRAM(nCSRAM), .nCSEXT(nCSEXT),
    .nCSEXTIO(nCSEXTIO), .nCSUART(nCSUART), .nXWAIT(nXWAIT), .MRDY(MRDY)
  );

  // Register model
  logic [7:0] m_w0, m_w1;
  logic [3:0] m_w2;
  logic       m_tmo;
  logic [7:0] last_rd;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic reset_model();
    m_w0 = 8'hFF; m_w1 = 8'hFF; m_w2 = 4'hF; m_tmo = 1'b0;
  endtask

  function automatic int exp_wait(input logic [5:0] s);
    if (!s[5]) return int'(m_w2);
    if (!s[4]) return int'(m_w1[7:4]);
    if (!s[3]) return int'(m_w1[3:0]);
    if (!s[2]) return int'(m_w0[7:4]);
    if (!s[1] || !s[0]) return int'(m_w0[3:0]);
    return 0;
  endfunction

  function automatic bit win(input logic [5:0] s, input logic [15:0] a);
    return (a[15:2] == BASE[15:2]) && !s[4];
  endfunction

  function automatic logic [7:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_w0;
      2'd1:    return m_w1;
      2'd2:    return {4'b0, m_w2};
      default: return {7'b0, m_tmo};
    endcase
  endfunction

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checki(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", nm, act, lo, hi, $time);
    end
  endtask

  // One CLKX4 cycle: present a phase, check the data bus mid-cycle, check MRDY after the edge
  task automatic tick(input logic [1:0] ph, input bit exp_m, input bit chk);
    {QX, EX} = ph;
    #2;
    if (EX && RnW) begin
      last_rd = DATA;
      check8("data_rd", DATA, win(sel_n, ADDR) ? exp_rd(ADDR[1:0]) : 8'bzzzzzzzz);
    end else if (RnW) begin
      check8("data_hiz", DATA, 8'bzzzzzzzz);
    end
    @(posedge CLKX4); #1;
    if (chk) check8("mrdy", {7'b0, MRDY}, {7'b0, exp_m});
  endtask

  task automatic idle(input int n, input logic [1:0] ph);
    sel_n = 6'h3F; RnW = 1'b1; tb_drv = 1'b0;
    for (int i = 0; i < n; i++) tick(ph, 1'b1, 1'b1);
  endtask

  // Full bus cycle as the E/Q generator runs it: 00, 10, 11, then 01 until MRDY is seen high
  task automatic access(input logic [5:0] s, input logic [15:0] a, input logic r,
                        input logic [7:0] wd, input int xw_rise, input bit chk,
                        output int lows, output int t_rdy);
    int  n, k, ones;
    bit  m_before;
    logic [1:0] ph;
    n = exp_wait(s);
    sel_n = s; ADDR = a; RnW = r; tb_dout = wd; tb_drv = ~r;
    if (xw_rise > 0) nXWAIT = 1'b0;
    lows = 0; t_rdy = 0; k = 0; ones = 0;
    for (int p = 0; p < 3; p++) begin
      k++;
      if (k == xw_rise) nXWAIT = 1'b1;
      ph = (p == 0) ? 2'b00 : (p == 1) ? 2'b10 : 2'b11;
      tick(ph, (p < 2) || (n == 0), chk);
      if (!MRDY) lows++;
    end
    if (MRDY) t_rdy = k;
    forever begin
      m_before = MRDY;
      k++; ones++;
      if (k == xw_rise) nXWAIT = 1'b1;
      tick(2'b01, ones >= n, chk);
      if (!MRDY) lows++;
      else if (t_rdy == 0) t_rdy = k;
      if (m_before) break;
      if (ones > 600) begin
        n_cmp++; n_bad++;
        $display("FAIL bound: MRDY stuck low for %0d cycles at %0t", ones, $time);
        break;
      end
    end
    if (!r && win(s, a)) begin
      case (a[1:0])
        2'd0:    m_w0 = wd;
        2'd1:    m_w1 = wd;
        2'd2:    m_w2 = wd[3:0];
        default: m_tmo = 1'b0;
      endcase
    end
    sel_n = 6'h3F; RnW = 1'b1; tb_drv = 1'b0;
`ifdef EXT_WAIT_XWAIT_EN
    nXWAIT = 1'b1;
`endif
    if (chk) checki("stretch", lows, n, n);
  endtask

  localparam logic [5:0] S_NONE  = 6'b111111;
  localparam logic [5:0] S_ROM0  = 6'b111110;
  localparam logic [5:0] S_ROM1  = 6'b111101;
  localparam logic [5:0] S_RAM   = 6'b111011;
  localparam logic [5:0] S_EXT   = 6'b110111;
  localparam logic [5:0] S_EXTIO = 6'b101111;
  localparam logic [5:0] S_UART  = 6'b011111;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lows, t_rdy, pick;
    logic [5:0]  s;
    logic [15:0] a;
    logic        r;
    nRESET = 1'b0; QX = 1'b0; EX = 1'b0; ADDR = '0; RnW = 1'b1;
    sel_n = 6'h3F; tb_drv = 1'b0; tb_dout = '0; nXWAIT = 1'b1; last_rd = '0;
    reset_model();
    repeat (3) @(posedge CLKX4);
    #1;
    check8("mrdy_in_reset", {7'b0, MRDY}, 8'h01);
    nRESET = 1'b1;
    idle(2, 2'b00);

    // Reset values
    access(S_EXTIO, {BASE[15:2], 2'd0}, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("extio_rst_stretch", lows, 15, 15);
    check8("wait0_rst", last_rd, 8'hFF);
    access(S_RAM, 16'h4000, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("ram_rst_stretch", lows, 15, 15);

    // WAIT0 = 20: RAM 2, ROM 0
    access(S_EXTIO, {BASE[15:2], 2'd0}, 1'b0, 8'h20, 0, 1'b1, lows, t_rdy);
    access(S_RAM, 16'h4000, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("ram_stretch_2", lows, 2, 2);
    access(S_ROM0, 16'hC000, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("rom0_no_stretch", lows, 0, 0);
    access(S_ROM1, 16'hE000, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("rom1_no_stretch", lows, 0, 0);

    // WAIT2 upper nibble is not stored
    access(S_EXTIO, {BASE[15:2], 2'd2}, 1'b0, 8'hA3, 0, 1'b1, lows, t_rdy);
    access(S_EXTIO, {BASE[15:2], 2'd2}, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    check8("wait2_rd", last_rd, 8'h03);
    access(S_UART, 16'hFE00, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("uart_stretch_3", lows, 3, 3);
    access(S_UART & S_RAM, 16'hFE00, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("uart_over_ram", lows, 3, 3);

    // A WAIT1 write during its own access applies from the next one
    access(S_EXTIO, {BASE[15:2], 2'd1}, 1'b0, 8'h50, 0, 1'b1, lows, t_rdy);
    checki("own_access_old", lows, 15, 15);
    access(S_EXTIO, {BASE[15:2], 2'd1}, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("own_access_new", lows, 5, 5);
    check8("wait1_rd", last_rd, 8'h50);

    // Generator halted in 01, and a cycle with no select
    idle(6, 2'b01);
    idle(1, 2'b00);
    access(S_NONE, 16'h1234, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("no_select", lows, 0, 0);

    // nXWAIT handling, WAIT1 = 0
    access(S_EXTIO, {BASE[15:2], 2'd1}, 1'b0, 8'h00, 0, 1'b1, lows, t_rdy);
`ifdef EXT_WAIT_XWAIT_EN
    access(S_EXT, 16'h8000, 1'b1, 8'h00, 11, 1'b0, lows, t_rdy);
    checki("xw_release", t_rdy - 11, 2, 3);
    access(S_EXT, 16'h8000, 1'b1, 8'h00, 10000, 1'b0, lows, t_rdy);
    checki("xw_timeout", lows, TMO, TMO + 1);
    m_tmo = 1'b1;
    access(S_EXTIO, {BASE[15:2], 2'd3}, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    check8("status_tmo", last_rd, 8'h01);
    access(S_EXTIO, {BASE[15:2], 2'd3}, 1'b0, 8'hFF, 0, 1'b1, lows, t_rdy);
    access(S_EXTIO, {BASE[15:2], 2'd3}, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    check8("status_clr", last_rd, 8'h00);
`else
    access(S_EXT, 16'h8000, 1'b1, 8'h00, 10000, 1'b1, lows, t_rdy);
    checki("xw_ignored", lows, 0, 0);
    access(S_EXTIO, {BASE[15:2], 2'd3}, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    check8("status_zero", last_rd, 8'h00);
`endif

    // Randomized bus cycles
    for (int i = 0; i < 250; i++) begin
      pick = $urandom_range(0, 7);
      if (pick < 6)       s = ~(6'd1 << pick);
      else if (pick == 6) s = S_NONE;
      else                s = 6'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        a = {BASE[15:2], 2'($urandom)};
        s[4] = 1'b0;
      end else begin
        a = 16'($urandom);
      end
      r = 1'($urandom);
`ifndef EXT_WAIT_XWAIT_EN
      nXWAIT = 1'($urandom);
`endif
      access(s, a, r, 8'($urandom), 0, 1'b1, lows, t_rdy);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 2'b00);
    end

    // Reset pulse in the middle of a 15-cycle stretch
    access(S_EXTIO, {BASE[15:2], 2'd0}, 1'b0, 8'hF0, 0, 1'b1, lows, t_rdy);
    sel_n = S_RAM; ADDR = 16'h4000; RnW = 1'b1; tb_drv = 1'b0;
    tick(2'b00, 1'b1, 1'b1);
    tick(2'b10, 1'b1, 1'b1);
    tick(2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(2'b01, 1'b0, 1'b1);
    #2 nRESET = 1'b0;
    #1 check8("mrdy_async_rst", {7'b0, MRDY}, 8'h01);
    #1 nRESET = 1'b1;
    reset_model();
    tick(2'b01, 1'b1, 1'b1);
    idle(2, 2'b00);
    access(S_EXTIO, {BASE[15:2], 2'd0}, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    check8("wait0_after_rst", last_rd, 8'hFF);
    checki("first_after_rst", lows, 15, 15);
    access(S_EXTIO, {BASE[15:2], 2'd2}, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    check8("wait2_after_rst", last_rd, 8'h0F);
    access(S_RAM, 16'h4000, 1'b1, 8'h00, 0, 1'b1, lows, t_rdy);
    checki("ram_after_rst", lows, 15, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
